// File: rtl/bpm_link_pkg.sv
// Shared definitions for both ends of the BPM Aurora link.
// Contents: header magic, word indices within a packet, status codes for the
// transmit and receive directions, bit offsets of the fields inside a 112-bit
// BPM reading, and a helper that builds any packet word from a reading.
package bpm_link_pkg;

    localparam logic [15:0] HEADER_MAGIC = 16'hA5BE;

    // Word positions within a 4-word packet
    localparam logic [1:0] W_HEADER = 2'd0;
    localparam logic [1:0] W_X      = 2'd1;
    localparam logic [1:0] W_Y      = 2'd2;
    localparam logic [1:0] W_S      = 2'd3;

    // Field offsets within the 112-bit reading
    localparam int HDR_LSB    = 96;
    localparam int X_LSB      = 64;
    localparam int Y_LSB      = 32;
    localparam int S_LSB      = 0;
    localparam int S_ZERO_BIT = 30;  // always sent as 0 in the S word

    typedef enum logic [1:0] {
        TX_SENT    = 2'd0,
        TX_OVERRUN = 2'd1,
        TX_ABORTED = 2'd2
    } tx_status_e;

    typedef enum logic [1:0] {
        RX_OK         = 2'd0,
        RX_BAD_HEADER = 2'd1,
        RX_BAD_LENGTH = 2'd2,
        RX_BAD_CRC    = 2'd3
    } rx_status_e;

    function automatic logic [31:0] bpm_word(input logic [15:0]  magic,
                                             input logic [1:0]   idx,
                                             input logic [111:0] d);
        logic [31:0] w;
        case (idx)
            W_HEADER: w = {magic, d[HDR_LSB +: 16]};
            W_X:      w = d[X_LSB +: 32];
            W_Y:      w = d[Y_LSB +: 32];
            default: begin
                w = d[S_LSB +: 32];
                w[S_ZERO_BIT] = 1'b0;
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/write_bpm_link.sv
// Transmit side of the BPM Aurora link.
// Serialises each accepted 112-bit reading into a 4-word AXI-Stream packet
// (header, X, Y, S; TLAST on S). One reading can wait in a pending slot while
// another is on the wire; a third is dropped and reported as an overrun.
// Ports:
//   clk, rst                 Aurora TX user clock, async active-high reset
//   channelUp                link up; dropping it mid-packet aborts the packet
//   inhibit                  masks inputStrobe entirely
//   inputStrobe, inputData   single-cycle reading strobe and payload
//   TDATA/TVALID/TREADY/TLAST  AXI-Stream to the Aurora TX user interface
//   statusStrobe, statusCode one-cycle event pulse: SENT / OVERRUN / ABORTED
//   packetCount, overrunCount  wrapping event counters
module write_bpm_link
    import bpm_link_pkg::*;
#(
    parameter logic [15:0] HEADER_MAGIC = bpm_link_pkg::HEADER_MAGIC,
    parameter string       dbg          = "false"
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         channelUp,
    input  logic         inhibit,
    input  logic         inputStrobe,
    input  logic [111:0] inputData,
    (* mark_debug = dbg *) output logic [31:0] TDATA,
    (* mark_debug = dbg *) output logic        TVALID,
    (* mark_debug = dbg *) input  logic        TREADY,
    (* mark_debug = dbg *) output logic        TLAST,
    (* mark_debug = dbg *) output logic        statusStrobe,
    (* mark_debug = dbg *) output logic [1:0]  statusCode,
    (* mark_debug = dbg *) output logic [15:0] packetCount,
    (* mark_debug = dbg *) output logic [15:0] overrunCount
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_X      = 3'd2,
        S_Y      = 3'd3,
        S_S      = 3'd4
    } state_e;

    (* mark_debug = dbg *) state_e       state;
    (* mark_debug = dbg *) logic [111:0] active;
    (* mark_debug = dbg *) logic [111:0] pending;
    (* mark_debug = dbg *) logic         pend_vld;

    logic         accept;
    logic         hs;
    logic         s_done;     // S word handshaken this cycle
    logic         load_new;   // a reading starts its header next cycle
    logic [111:0] load_src;
    state_e       adv_state;  // state after a non-final handshake
    logic [1:0]   adv_idx;

    assign accept = inputStrobe && !inhibit && channelUp;
    assign hs     = TVALID && TREADY;
    assign s_done = (state == S_S) && hs;

    always_comb begin
        load_src = inputData;
        load_new = 1'b0;
        if (state == S_IDLE) begin
            load_new = accept;
        end else if (s_done) begin
            // The queued reading is older, so it goes first
            load_new = pend_vld || accept;
            load_src = pend_vld ? pending : inputData;
        end
    end

    always_comb begin
        adv_state = S_IDLE;
        adv_idx   = W_HEADER;
        case (state)
            S_HEADER: begin adv_state = S_X; adv_idx = W_X; end
            S_X:      begin adv_state = S_Y; adv_idx = W_Y; end
            S_Y:      begin adv_state = S_S; adv_idx = W_S; end
            default:  begin adv_state = S_IDLE; adv_idx = W_HEADER; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            active       <= '0;
            pending      <= '0;
            pend_vld     <= 1'b0;
            TDATA        <= '0;
            TVALID       <= 1'b0;
            TLAST        <= 1'b0;
            statusStrobe <= 1'b0;
            statusCode   <= TX_SENT;
            packetCount  <= '0;
            overrunCount <= '0;
        end else begin
            statusStrobe <= 1'b0;
            if (state != S_IDLE && !channelUp) begin
                // Link lost: drop everything; an accept is impossible here
                state        <= S_IDLE;
                TVALID       <= 1'b0;
                TLAST        <= 1'b0;
                pend_vld     <= 1'b0;
                statusStrobe <= 1'b1;
                statusCode   <= TX_ABORTED;
            end else begin
                // Strobe while busy and not finishing: queue or drop
                if (accept && state != S_IDLE && !s_done) begin
                    if (!pend_vld) begin
                        pending  <= inputData;
                        pend_vld <= 1'b1;
                    end else begin
                        overrunCount <= overrunCount + 16'd1;
                        statusStrobe <= 1'b1;
                        statusCode   <= TX_OVERRUN;
                    end
                end

                if (s_done) begin
                    statusStrobe <= 1'b1;
                    statusCode   <= TX_SENT;
                    packetCount  <= packetCount + 16'd1;
                    // pending moves to active; a same-cycle strobe refills it
                    if (pend_vld && accept) pending <= inputData;
                    pend_vld <= pend_vld && accept;
                end

                if (load_new) begin
                    active <= load_src;
                    state  <= S_HEADER;
                    TVALID <= 1'b1;
                    TLAST  <= 1'b0;
                    TDATA  <= bpm_word(HEADER_MAGIC, W_HEADER, load_src);
                end else if (s_done) begin
                    state  <= S_IDLE;
                    TVALID <= 1'b0;
                    TLAST  <= 1'b0;
                end else if (hs) begin
                    state <= adv_state;
                    TDATA <= bpm_word(HEADER_MAGIC, adv_idx, active);
                    TLAST <= (adv_idx == W_S);
                end
            end
        end
    end

endmodule
